// File: rtl/jump_ctrl_if.sv
// Decoder/PC-facing bundle for jump_ctrl: jump requests, LUT write port,
// jump output and status.
interface jump_ctrl_if #(
   parameter int D     = 10,
   parameter int LUT_W = 4,
   parameter int DEPTH = 4
);
   logic [D-1:0]                 prog_ctr;
   logic                         br_en;
   logic                         br_cond;
   logic                         call_en;
   logic                         ret_en;
   logic [LUT_W-1:0]             lut_idx;
   logic                         lut_wr_en;
   logic [LUT_W-1:0]             lut_wr_idx;
   logic [D-1:0]                 lut_wr_data;
   logic                         absjump_en;
   logic [D-1:0]                 target;
   logic [$clog2(DEPTH+1)-1:0]   depth;
   logic                         err_ovf;
   logic                         err_unf;
   logic                         err_multi;

   modport master (
      output prog_ctr, br_en, br_cond, call_en, ret_en, lut_idx,
             lut_wr_en, lut_wr_idx, lut_wr_data,
      input  absjump_en, target, depth, err_ovf, err_unf, err_multi
   );

   modport slave (
      input  prog_ctr, br_en, br_cond, call_en, ret_en, lut_idx,
             lut_wr_en, lut_wr_idx, lut_wr_data,
      output absjump_en, target, depth, err_ovf, err_unf, err_multi
   );
endinterface

// File: rtl/jump_ctrl.sv
// Jump-request generator: resolves branch/call/return into one absolute PC
// target per cycle, backed by a writable target LUT and a link stack.
module jump_ctrl #(
   parameter int D     = 10,
   parameter int LUT_W = 4,
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   jump_ctrl_if.slave  bus
);
   localparam int DW      = $clog2(DEPTH + 1);
   localparam int LUT_N   = 2 ** LUT_W;

   logic [D-1:0]  lut   [LUT_N];
   logic [D-1:0]  stack [DEPTH];
   logic [DW-1:0] depth_q;
   logic          err_ovf_q;
   logic          err_unf_q;
   logic          err_multi_q;

   logic          do_ret;
   logic          do_call;
   logic          do_br;
   logic          stack_empty;
   logic          stack_full;
   logic          multi_req;
   logic [DW-1:0] top_idx;
   logic [D-1:0]  top_val;
   logic [D-1:0]  link_addr;

   // Fixed priority: return beats call beats branch.
   assign do_ret      = bus.ret_en;
   assign do_call     = bus.call_en & ~bus.ret_en;
   assign do_br       = bus.br_en & ~bus.call_en & ~bus.ret_en;
   assign multi_req   = (bus.br_en & bus.call_en) | (bus.br_en & bus.ret_en) |
                        (bus.call_en & bus.ret_en);
   assign stack_empty = (depth_q == '0);
   assign stack_full  = (depth_q == DW'(DEPTH));
   assign top_idx     = depth_q - DW'(1);
   assign link_addr   = bus.prog_ctr + D'(1);

   always_comb begin
      top_val = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (top_idx == DW'(i)) top_val = stack[i];
      end
   end

   always_comb begin
      bus.absjump_en = 1'b0;
      bus.target     = '0;
      if (!reset) begin
         if (do_ret) begin
            if (!stack_empty) begin
               bus.absjump_en = 1'b1;
               bus.target     = top_val;
            end
         end else if (do_call) begin
            bus.absjump_en = 1'b1;
            bus.target     = lut[bus.lut_idx];
         end else if (do_br) begin
            bus.absjump_en = bus.br_cond;
            bus.target     = lut[bus.lut_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
         depth_q     <= '0;
         err_ovf_q   <= 1'b0;
         err_unf_q   <= 1'b0;
         err_multi_q <= 1'b0;
      end else begin
         if (bus.lut_wr_en) lut[bus.lut_wr_idx] <= bus.lut_wr_data;

         if (do_ret) begin
            if (stack_empty) err_unf_q <= 1'b1;
            else             depth_q   <= depth_q - DW'(1);
         end else if (do_call) begin
            if (stack_full) begin
               err_ovf_q <= 1'b1;
            end else begin
               for (int i = 0; i < DEPTH; i++) begin
                  if (depth_q == DW'(i)) stack[i] <= link_addr;
               end
               depth_q <= depth_q + DW'(1);
            end
         end

         if (multi_req) err_multi_q <= 1'b1;
      end
   end

   assign bus.depth     = depth_q;
   assign bus.err_ovf   = err_ovf_q;
   assign bus.err_unf   = err_unf_q;
   assign bus.err_multi = err_multi_q;
endmodule
